// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard scoreboard: per-register countdown of outstanding writes,
// RAW/WAW/MDU-structural stall generation, decode bypass select and a
// saturating stall-cycle counter.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 8,
    parameter int LAT_W    = 4,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs,
    input  logic [ADDR_W-1:0]   issue_rt,
    input  logic                issue_rs_used,
    input  logic                issue_rt_used,
    input  logic                issue_we,
    input  logic [ADDR_W-1:0]   issue_waddr,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                issue_long,
    input  logic                flush_d,
    output logic                stall_d,
    output logic                issue_fire,
    output logic                fwd_a,
    output logic                fwd_b,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                mdu_busy,
    output logic [PERF_W-1:0]   stall_cycles
);

    logic [LAT_W-1:0]  cnt [NUM_REGS];
    logic [LAT_W-1:0]  mduCnt;
    logic [PERF_W-1:0] stallCount;

    logic [LAT_W-1:0]  latClamped;
    logic [LAT_W-1:0]  rsCnt;
    logic [LAT_W-1:0]  rtCnt;
    logic [LAT_W-1:0]  wrCnt;
    logic              rsLive;
    logic              rtLive;
    logic              wrLive;
    logic              rawA;
    logic              rawB;
    logic              waw;
    logic              strc;
    logic              liveIssue;
    logic              writeEn;

    // Latency 0 behaves as a single-cycle producer; anything beyond MAX_LAT is capped.
    always_comb begin
        latClamped = issue_lat;
        if (issue_lat == '0) begin
            latClamped = LAT_W'(1);
        end else if (issue_lat > LAT_W'(MAX_LAT)) begin
            latClamped = LAT_W'(MAX_LAT);
        end
    end

    // Hazard detection, stall, issue and bypass selection for the decode instruction.
    always_comb begin
        rsCnt     = cnt[issue_rs];
        rtCnt     = cnt[issue_rt];
        wrCnt     = cnt[issue_waddr];
        rsLive    = issue_rs_used & (issue_rs != '0);
        rtLive    = issue_rt_used & (issue_rt != '0);
        wrLive    = issue_we & (issue_waddr != '0);
        rawA      = rsLive & (rsCnt > LAT_W'(1));
        rawB      = rtLive & (rtCnt > LAT_W'(1));
        // The older write must land strictly before the new one, otherwise it would clobber it.
        waw       = wrLive & (wrCnt >= latClamped);
        strc      = issue_long & (mduCnt > LAT_W'(1));
        liveIssue = issue_valid & ~flush_d;
        stall_d   = liveIssue & (rawA | rawB | waw | strc);
        issue_fire = liveIssue & ~stall_d;
        // A result is on the completing-result bus during its final countdown cycle.
        fwd_a     = issue_valid & rsLive & (rsCnt == LAT_W'(1));
        fwd_b     = issue_valid & rtLive & (rtCnt == LAT_W'(1));
        writeEn   = issue_fire & wrLive;
    end

    // Per-register countdown; a new write overrides the decrement, $zero never changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (writeEn && (issue_waddr == ADDR_W'(r))) begin
                    cnt[r] <= latClamped;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // MDU occupancy countdown, reloaded when a long-latency instruction issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            mduCnt <= '0;
        end else if (issue_fire && issue_long) begin
            mduCnt <= latClamped;
        end else if (mduCnt != '0) begin
            mduCnt <= mduCnt - LAT_W'(1);
        end
    end

    // Saturating count of decode stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stall_d && (stallCount != '1)) begin
            stallCount <= stallCount + PERF_W'(1);
        end
    end

    // Outstanding-write view of the scoreboard, taken straight from the counters.
    always_comb begin
        pending_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (cnt[r] != '0);
        end
    end

    assign mdu_busy     = (mduCnt > LAT_W'(1));
    assign stall_cycles = stallCount;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: inputs change 1 time unit after
// each rising edge, outputs are checked 1 time unit later.
module tb_hazard_scoreboard_unit;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_rs_used;
    logic        issue_rt_used;
    logic        issue_we;
    logic [4:0]  issue_waddr;
    logic [3:0]  issue_lat;
    logic        issue_long;
    logic        flush_d;
    logic        stall_d;
    logic        issue_fire;
    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] pending_mask;
    logic        mdu_busy;
    logic [31:0] stall_cycles;

    int vectors;
    int miscompares;

    hazard_scoreboard_unit #(
        .NUM_REGS(32), .ADDR_W(5), .MAX_LAT(8), .LAT_W(4), .PERF_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_rs(issue_rs),
        .issue_rt(issue_rt),
        .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used),
        .issue_we(issue_we),
        .issue_waddr(issue_waddr),
        .issue_lat(issue_lat),
        .issue_long(issue_long),
        .flush_d(flush_d),
        .stall_d(stall_d),
        .issue_fire(issue_fire),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b),
        .pending_mask(pending_mask),
        .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsU,
                         input logic [4:0] rt, input logic rtU, input logic we,
                         input logic [4:0] wa, input logic [3:0] lat,
                         input logic lng, input logic fl);
        issue_valid   = v;
        issue_rs      = rs;
        issue_rs_used = rsU;
        issue_rt      = rt;
        issue_rt_used = rtU;
        issue_we      = we;
        issue_waddr   = wa;
        issue_lat     = lat;
        issue_long    = lng;
        flush_d       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
    endtask

    // advance to the next cycle: just past the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk1 ("rst_stall", stall_d, 1'b0);
        chk1 ("rst_fire", issue_fire, 1'b0);
        chk1 ("rst_fwda", fwd_a, 1'b0);
        chk1 ("rst_fwdb", fwd_b, 1'b0);
        chk32("rst_pend", pending_mask, 32'h0);
        chk1 ("rst_mdu", mdu_busy, 1'b0);
        chk32("rst_cycles", stall_cycles, 32'd0);

        // 1: ALU producer forwards back-to-back
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 4'd1, 1'b0, 1'b0); #1;
        chk1 ("t1_fire0", issue_fire, 1'b1);
        cyc(); drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0, 1'b0); #1;
        chk1 ("t1_stall", stall_d, 1'b0);
        chk1 ("t1_fwda", fwd_a, 1'b1);
        chk32("t1_pend1", pending_mask, 32'h0000_0008);
        cyc(); idle(); #1;
        chk32("t1_pend2", pending_mask, 32'h0);
        chk1 ("t1_idle_fwd", fwd_a, 1'b0);

        // 2: load-use costs one bubble
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 4'd2, 1'b0, 1'b0); #1;
        chk1 ("t2_fire0", issue_fire, 1'b1);
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 4'd1, 1'b0, 1'b0); #1;
        chk1 ("t2_stall", stall_d, 1'b1);
        chk1 ("t2_fwdb0", fwd_b, 1'b0);
        chk1 ("t2_nofire", issue_fire, 1'b0);
        cyc(); #1;
        chk1 ("t2_fwdb1", fwd_b, 1'b1);
        chk1 ("t2_fire2", issue_fire, 1'b1);
        chk32("t2_cycles", stall_cycles, 32'd1);

        // 3: MDU structural hazard
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 4'd6, 1'b1, 1'b0); #1;
        chk1 ("t3_fire0", issue_fire, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1, 1'b1, 1'b0); #1;
            chk1 ("t3_stall", stall_d, 1'b1);
            chk1 ("t3_busy", mdu_busy, 1'b1);
        end
        cyc(); #1;
        chk1 ("t3_fire6", issue_fire, 1'b1);
        chk1 ("t3_busy6", mdu_busy, 1'b0);
        cyc(); idle(); #1;
        chk32("t3_cycles", stall_cycles, 32'd6);

        // 4: WAW on $5 while an older long write is outstanding
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 4'd6, 1'b0, 1'b0); #1;
        chk1 ("t4_fire0", issue_fire, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 4'd2, 1'b0, 1'b0); #1;
            chk1 ("t4_stall", stall_d, 1'b1);
            chk32("t4_pend", pending_mask, 32'h0000_0020);
        end
        cyc(); #1;
        chk1 ("t4_fire6", issue_fire, 1'b1);
        chk1 ("t4_stall6", stall_d, 1'b0);
        cyc(); idle(); #1;
        chk32("t4_pend7", pending_mask, 32'h0000_0020);
        chk32("t4_cycles", stall_cycles, 32'd11);
        cyc(); #1;
        cyc(); #1;
        chk32("t4_pend9", pending_mask, 32'h0);

        // 5: $zero is never tracked
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 4'd4, 1'b0, 1'b0); #1;
        chk1 ("t5_fire0", issue_fire, 1'b1);
        cyc(); drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 4'd1, 1'b0, 1'b0); #1;
        chk32("t5_pend", pending_mask, 32'h0);
        chk1 ("t5_stall", stall_d, 1'b0);
        chk1 ("t5_fwda", fwd_a, 1'b0);
        chk1 ("t5_fwdb", fwd_b, 1'b0);

        // latency clamping: 0 acts as 1, 15 caps at 8
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 4'd0, 1'b0, 1'b0); #1;
        chk1 ("lat0_fire", issue_fire, 1'b1);
        cyc(); drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 4'd15, 1'b0, 1'b0); #1;
        chk1 ("lat0_fwda", fwd_a, 1'b1);
        chk1 ("lat0_stall", stall_d, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cyc(); idle(); #1;
            chk1("lat15_pend", pending_mask[9], 1'b1);
        end
        cyc(); #1;
        chk32("lat15_done", pending_mask, 32'h0);

        // 6: flush overrides a hazard, then reset drops all outstanding state
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 4'd4, 1'b1, 1'b0); #1;
        chk1 ("t6_mdufire", issue_fire, 1'b1);
        cyc(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 4'd5, 1'b0, 1'b0); #1;
        chk1 ("t6_wrfire", issue_fire, 1'b1);
        cyc(); drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0, 1'b0); #1;
        chk1 ("t6_rawstall", stall_d, 1'b1);
        chk32("t6_pend", pending_mask, 32'h0000_0080);
        chk1 ("t6_busy", mdu_busy, 1'b1);
        flush_d = 1'b1;
        #1;
        chk1 ("t6_flstall", stall_d, 1'b0);
        chk1 ("t6_flfire", issue_fire, 1'b0);
        reset = 1'b1;
        cyc(); reset = 1'b0; idle(); #1;
        chk32("t6_rpend", pending_mask, 32'h0);
        chk1 ("t6_rbusy", mdu_busy, 1'b0);
        chk32("t6_rcycles", stall_cycles, 32'd0);
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 4'd1, 1'b1, 1'b0); #1;
        chk1 ("t6_rnostall", stall_d, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
